// File: rtl/serv_issue_ctrl_if.sv
// serv_issue_ctrl_if: ibus, decoder, dbus and counter signals of the issue sequencer.
interface serv_issue_ctrl_if;
    logic [31:0] i_pc;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic [31:0] i_ibus_rdt;
    logic        i_ibus_ack;
    logic [29:0] o_dec_rdt;
    logic        o_dec_en;
    logic        i_two_stage_op;
    logic        i_dbus_en;
    logic        o_dbus_cyc;
    logic        i_dbus_ack;
    logic        o_init;
    logic        o_cnt_en;
    logic [4:0]  o_cnt;
    logic        o_cnt_done;
    logic        o_pc_en;
    logic [2:0]  o_state;

    modport master (
        input  i_pc, i_ibus_rdt, i_ibus_ack, i_two_stage_op, i_dbus_en, i_dbus_ack,
        output o_ibus_adr, o_ibus_cyc, o_dec_rdt, o_dec_en, o_dbus_cyc, o_init,
               o_cnt_en, o_cnt, o_cnt_done, o_pc_en, o_state
    );

    modport slave (
        output i_pc, i_ibus_rdt, i_ibus_ack, i_two_stage_op, i_dbus_en, i_dbus_ack,
        input  o_ibus_adr, o_ibus_cyc, o_dec_rdt, o_dec_en, o_dbus_cyc, o_init,
               o_cnt_en, o_cnt, o_cnt_done, o_pc_en, o_state
    );
endinterface

// File: rtl/serv_issue_ctrl.sv
// serv_issue_ctrl: fetch, decode, init/memwait/run sequencing for the bit-serial core.
module serv_issue_ctrl #(
    parameter int          W        = 1,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic          clk,
    input logic          i_rst_n,
    serv_issue_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, INIT, MEMWAIT, RUN} state_t;

    localparam logic [4:0] STEP = 5'(W);
    localparam logic [4:0] LAST = 5'(32 - W);

    if (W != 1 && W != 4) begin : g_bad_w
        $error("serv_issue_ctrl: W must be 1 or 4");
    end
    if (RESET_PC[0]) begin : g_bad_pc
        $error("serv_issue_ctrl: RESET_PC must be even");
    end

    state_t     state, nxt;
    logic       ph, dbus_q, nxt_en, nxt_done;
    logic [4:0] nxt_cnt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = FETCH;
            FETCH:   nxt = bus.i_ibus_ack ? DECODE : FETCH;
            DECODE:  nxt = !ph ? DECODE : bus.i_two_stage_op ? INIT : bus.i_dbus_en ? MEMWAIT : RUN;
            INIT:    nxt = !bus.o_cnt_done ? INIT : dbus_q ? MEMWAIT : RUN;
            MEMWAIT: nxt = bus.i_dbus_ack ? RUN : MEMWAIT;
            RUN:     nxt = bus.o_cnt_done ? FETCH : RUN;
            default: nxt = IDLE;
        endcase
    end

    // outputs are registered from the next state, so they line up with it
    assign nxt_cnt  = bus.o_cnt_en ? bus.o_cnt + STEP : bus.o_cnt;
    assign nxt_en   = nxt == INIT || nxt == RUN;
    assign nxt_done = nxt_en && nxt_cnt == LAST;

    assign bus.o_ibus_adr = bus.i_pc;
    assign bus.o_state    = state;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            ph             <= 1'b0;
            dbus_q         <= 1'b0;
            bus.o_dec_rdt  <= '0;
            bus.o_ibus_cyc <= 1'b0;
            bus.o_dec_en   <= 1'b0;
            bus.o_dbus_cyc <= 1'b0;
            bus.o_init     <= 1'b0;
            bus.o_cnt_en   <= 1'b0;
            bus.o_cnt      <= '0;
            bus.o_cnt_done <= 1'b0;
            bus.o_pc_en    <= 1'b0;
        end else begin
            state          <= nxt;
            ph             <= state == DECODE && !ph;
            if (state == DECODE && ph)
                dbus_q <= bus.i_dbus_en;
            if (state == FETCH && bus.i_ibus_ack)
                bus.o_dec_rdt <= bus.i_ibus_rdt[31:2];
            bus.o_ibus_cyc <= nxt == FETCH;
            bus.o_dec_en   <= state == FETCH && bus.i_ibus_ack;
            bus.o_dbus_cyc <= nxt == MEMWAIT;
            bus.o_init     <= nxt == INIT;
            bus.o_cnt_en   <= nxt_en;
            bus.o_cnt      <= nxt_cnt;
            bus.o_cnt_done <= nxt_done;
            bus.o_pc_en    <= nxt_done && nxt == RUN;
        end
    end
endmodule

// File: tb/tb_serv_issue_ctrl.sv
// tb_serv_issue_ctrl: directed scenarios for the issue sequencer at W=1 and W=4.
module tb_serv_issue_ctrl;
    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 clk = ~clk;

    serv_issue_ctrl_if b();
    serv_issue_ctrl_if b4();

    serv_issue_ctrl #(.W(1)) dut  (.clk(clk), .i_rst_n(i_rst_n), .bus(b.master));
    serv_issue_ctrl #(.W(4)) dut4 (.clk(clk), .i_rst_n(i_rst_n), .bus(b4.master));

    int tests = 0;
    int fails = 0;

    int n_dec_en, dec_en_at, n_init, n_run, n_dbus, n_pc_en, pc_en_at, cyc_at;
    int bad_cnt, mw_bad, init_done, pc_in_init;
    logic [29:0] rdt_cap;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issues one instruction with ack in the current FETCH cycle (offset 0) and
    // observes every cycle until o_ibus_cyc returns; decoder inputs carry the
    // wrong value everywhere except DECODE cycle 1
    task automatic issue(input logic [31:0] instr, input logic ts, input logic de,
                         input int dly, input logic spur);
        int exp_cnt, m;
        n_dec_en = 0; dec_en_at = -1; n_init = 0; n_run = 0; n_dbus = 0;
        n_pc_en = 0; pc_en_at = -1; cyc_at = -1; bad_cnt = 0; mw_bad = 0;
        init_done = 0; pc_in_init = 0; exp_cnt = 0; m = 0; rdt_cap = '0;
        b.i_ibus_rdt = instr;
        b.i_ibus_ack = 1'b1;
        b.i_two_stage_op = ~ts;
        b.i_dbus_en = ~de;
        for (int k = 1; k <= 200; k++) begin
            tick;
            b.i_ibus_ack = spur && k == 10;
            b.i_dbus_ack = spur && k == 12;
            b.i_two_stage_op = (k == 2) ? ts : ~ts;
            b.i_dbus_en = (k == 2) ? de : ~de;
            if (k == 1) rdt_cap = b.o_dec_rdt;
            if (b.o_dec_en) begin
                n_dec_en++;
                if (dec_en_at < 0) dec_en_at = k;
            end
            if (b.o_cnt_en) begin
                if (b.o_init) n_init++; else n_run++;
                if (b.o_cnt !== 5'(exp_cnt)) bad_cnt++;
                if (b.o_cnt_done !== (exp_cnt == 31)) bad_cnt++;
                exp_cnt = (exp_cnt + 1) % 32;
            end else if (b.o_cnt_done) bad_cnt++;
            if (b.o_dbus_cyc) begin
                m++;
                n_dbus++;
                if (b.o_cnt !== 5'd0 || b.o_cnt_en) mw_bad++;
                b.i_dbus_ack = (m == dly + 1);
            end
            if (b.o_cnt_done && b.o_init) init_done++;
            if (b.o_pc_en) begin
                n_pc_en++;
                pc_en_at = k;
                if (b.o_init) pc_in_init++;
            end
            if (b.o_ibus_cyc) begin
                cyc_at = k;
                break;
            end
        end
        b.i_ibus_ack = 1'b0;
        b.i_dbus_ack = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        tests++; if ({b.o_ibus_cyc, b.o_dec_en, b.o_dbus_cyc, b.o_init, b.o_cnt_en, b.o_cnt_done, b.o_pc_en} !== 7'd0) begin fails++; $display("FAIL reset_flags: got %b expected 0000000", {b.o_ibus_cyc, b.o_dec_en, b.o_dbus_cyc, b.o_init, b.o_cnt_en, b.o_cnt_done, b.o_pc_en}); end
        tests++; if (b.o_cnt !== 5'd0 || b.o_dec_rdt !== 30'd0) begin fails++; $display("FAIL reset_cnt_rdt: got cnt=%0d rdt=%h expected 0/0", b.o_cnt, b.o_dec_rdt); end
        tests++; if (b.o_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", b.o_state); end
        i_rst_n = 1'b1;
        tests++; if (b.o_state !== 3'd0 || b.o_ibus_cyc !== 1'b0) begin fails++; $display("FAIL reset_idle: got state=%0d cyc=%b expected 0/0", b.o_state, b.o_ibus_cyc); end
        tick;
        tests++; if (b.o_state !== 3'd1 || b.o_ibus_cyc !== 1'b1) begin fails++; $display("FAIL reset_fetch: got state=%0d cyc=%b expected 1/1", b.o_state, b.o_ibus_cyc); end
        tests++; if (b4.o_state !== 3'd1) begin fails++; $display("FAIL reset_fetch_w4: got %0d expected 1", b4.o_state); end
    endtask

    task automatic test_ibus_wait;
        for (int i = 0; i < 5; i++) begin
            b.i_pc = 32'h0000_1000 + 32'(i * 4);
            #1;
            tests++; if (b.o_ibus_cyc !== 1'b1 || b.o_dec_en !== 1'b0) begin fails++; $display("FAIL wait_cyc[%0d]: got cyc=%b dec_en=%b expected 1/0", i, b.o_ibus_cyc, b.o_dec_en); end
            tests++; if (b.o_ibus_adr !== 32'h0000_1000 + 32'(i * 4)) begin fails++; $display("FAIL wait_adr[%0d]: got %h expected %h", i, b.o_ibus_adr, 32'h0000_1000 + 32'(i * 4)); end
            tick;
        end
    endtask

    task automatic test_addi;
        tests++; if (b.o_ibus_cyc !== 1'b1) begin fails++; $display("FAIL addi_precyc: got %b expected 1", b.o_ibus_cyc); end
        issue(32'h1230_0093, 1'b0, 1'b0, 0, 1'b1);
        tests++; if (rdt_cap !== 30'h048C_0024) begin fails++; $display("FAIL addi_rdt: got %h expected 048c0024", rdt_cap); end
        tests++; if (n_dec_en !== 1 || dec_en_at !== 1) begin fails++; $display("FAIL addi_dec_en: got n=%0d at=%0d expected 1/1", n_dec_en, dec_en_at); end
        tests++; if (n_init !== 0 || n_dbus !== 0) begin fails++; $display("FAIL addi_no_init: got init=%0d dbus=%0d expected 0/0", n_init, n_dbus); end
        tests++; if (n_run !== 32 || bad_cnt !== 0) begin fails++; $display("FAIL addi_run: got run=%0d bad=%0d expected 32/0", n_run, bad_cnt); end
        tests++; if (n_pc_en !== 1 || pc_en_at !== 34) begin fails++; $display("FAIL addi_pc_en: got n=%0d at=%0d expected 1/34", n_pc_en, pc_en_at); end
        tests++; if (cyc_at !== 35) begin fails++; $display("FAIL addi_refetch: got %0d expected 35", cyc_at); end
    endtask

    task automatic test_beq;
        issue(32'h0000_0063, 1'b1, 1'b0, 0, 1'b0);
        tests++; if (n_init !== 32 || init_done !== 1 || pc_in_init !== 0) begin fails++; $display("FAIL beq_init: got init=%0d done=%0d pc=%0d expected 32/1/0", n_init, init_done, pc_in_init); end
        tests++; if (n_run !== 32 || bad_cnt !== 0 || n_dbus !== 0) begin fails++; $display("FAIL beq_run: got run=%0d bad=%0d dbus=%0d expected 32/0/0", n_run, bad_cnt, n_dbus); end
        tests++; if (n_pc_en !== 1 || pc_en_at !== 66) begin fails++; $display("FAIL beq_pc_en: got n=%0d at=%0d expected 1/66", n_pc_en, pc_en_at); end
        tests++; if (cyc_at !== 67) begin fails++; $display("FAIL beq_refetch: got %0d expected 67", cyc_at); end
    endtask

    task automatic test_lw;
        issue(32'h0001_2083, 1'b1, 1'b1, 3, 1'b0);
        tests++; if (n_init !== 32 || n_dbus !== 4 || mw_bad !== 0) begin fails++; $display("FAIL lw_memwait: got init=%0d dbus=%0d bad=%0d expected 32/4/0", n_init, n_dbus, mw_bad); end
        tests++; if (n_run !== 32 || bad_cnt !== 0) begin fails++; $display("FAIL lw_run: got run=%0d bad=%0d expected 32/0", n_run, bad_cnt); end
        tests++; if (pc_en_at !== 70 || cyc_at !== 71) begin fails++; $display("FAIL lw_timing: got pc=%0d cyc=%0d expected 70/71", pc_en_at, cyc_at); end
    endtask

    task automatic test_store_direct;
        issue(32'h0011_2023, 1'b0, 1'b1, 0, 1'b0);
        tests++; if (n_init !== 0 || n_dbus !== 1 || mw_bad !== 0) begin fails++; $display("FAIL sw_memwait: got init=%0d dbus=%0d bad=%0d expected 0/1/0", n_init, n_dbus, mw_bad); end
        tests++; if (n_run !== 32 || pc_en_at !== 35 || cyc_at !== 36) begin fails++; $display("FAIL sw_timing: got run=%0d pc=%0d cyc=%0d expected 32/35/36", n_run, pc_en_at, cyc_at); end
    endtask

    task automatic test_mid_reset;
        logic found;
        found = 1'b0;
        b.i_ibus_rdt = 32'h1230_0093;
        b.i_two_stage_op = 1'b0;
        b.i_dbus_en = 1'b0;
        b.i_ibus_ack = 1'b1;
        for (int k = 0; k < 60 && !found; k++) begin
            tick;
            b.i_ibus_ack = 1'b0;
            found = b.o_cnt_en && b.o_cnt == 5'd17;
        end
        tests++; if (!found) begin fails++; $display("FAIL midrst_reach: got no cnt=17 expected cnt=17 in RUN"); end
        #2 i_rst_n = 1'b0;
        #1;
        tests++; if ({b.o_ibus_cyc, b.o_dec_en, b.o_dbus_cyc, b.o_init, b.o_cnt_en, b.o_cnt_done, b.o_pc_en} !== 7'd0 || b.o_cnt !== 5'd0 || b.o_state !== 3'd0) begin fails++; $display("FAIL midrst_async: got flags=%b cnt=%0d state=%0d expected 0/0/0", {b.o_ibus_cyc, b.o_dec_en, b.o_dbus_cyc, b.o_init, b.o_cnt_en, b.o_cnt_done, b.o_pc_en}, b.o_cnt, b.o_state); end
        tick;
        i_rst_n = 1'b1;
        tests++; if (b.o_state !== 3'd0 || b.o_ibus_cyc !== 1'b0) begin fails++; $display("FAIL midrst_idle: got state=%0d cyc=%b expected 0/0", b.o_state, b.o_ibus_cyc); end
        tick;
        tests++; if (b.o_state !== 3'd1 || b.o_ibus_cyc !== 1'b1) begin fails++; $display("FAIL midrst_fetch: got state=%0d cyc=%b expected 1/1", b.o_state, b.o_ibus_cyc); end
    endtask

    task automatic test_w4;
        int run, bad, exp_cnt, pc_at, cyc4, cnt_at_pc;
        logic done_at_pc;
        run = 0; bad = 0; exp_cnt = 0; pc_at = -1; cyc4 = -1; cnt_at_pc = -1; done_at_pc = 1'b0;
        tests++; if (b4.o_ibus_cyc !== 1'b1) begin fails++; $display("FAIL w4_precyc: got %b expected 1", b4.o_ibus_cyc); end
        b4.i_ibus_rdt = 32'h1230_0093;
        b4.i_two_stage_op = 1'b0;
        b4.i_dbus_en = 1'b0;
        b4.i_ibus_ack = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            b4.i_ibus_ack = 1'b0;
            if (b4.o_cnt_en) begin
                run++;
                if (b4.o_cnt !== 5'(exp_cnt)) bad++;
                exp_cnt = (exp_cnt + 4) % 32;
            end
            if (b4.o_pc_en) begin
                pc_at = k;
                cnt_at_pc = int'(b4.o_cnt);
                done_at_pc = b4.o_cnt_done;
            end
            if (b4.o_ibus_cyc) begin
                cyc4 = k;
                break;
            end
        end
        tests++; if (run !== 8 || bad !== 0) begin fails++; $display("FAIL w4_run: got run=%0d bad=%0d expected 8/0", run, bad); end
        tests++; if (pc_at !== 10 || cnt_at_pc !== 28 || done_at_pc !== 1'b1) begin fails++; $display("FAIL w4_pc_en: got at=%0d cnt=%0d done=%b expected 10/28/1", pc_at, cnt_at_pc, done_at_pc); end
        tests++; if (cyc4 !== 11) begin fails++; $display("FAIL w4_refetch: got %0d expected 11", cyc4); end
    endtask

    initial begin
        b.i_pc = 32'h0000_0100; b.i_ibus_rdt = '0; b.i_ibus_ack = 1'b0;
        b.i_two_stage_op = 1'b0; b.i_dbus_en = 1'b0; b.i_dbus_ack = 1'b0;
        b4.i_pc = 32'h0000_0200; b4.i_ibus_rdt = '0; b4.i_ibus_ack = 1'b0;
        b4.i_two_stage_op = 1'b0; b4.i_dbus_en = 1'b0; b4.i_dbus_ack = 1'b0;
        test_reset;
        test_ibus_wait;
        test_addi;
        test_beq;
        test_lw;
        test_store_direct;
        test_mid_reset;
        test_w4;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
